// File: rtl/cut_driver.sv
// Cutter stepper half-step sequencer with linear start ramp; first step START_PERIOD cycles after entering RUN.
// Outputs are decoded from registered state; no backpressure, en_i is a level consumed every cycle.
module cut_driver #(
    parameter int START_PERIOD = 1000,
    parameter int STEP_PERIOD  = 250,
    parameter int RAMP_DEC     = 50,
    parameter int HOLD_EN      = 0,
    parameter int POS_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             direction_i,
    output logic [3:0]       coil_o,
    output logic             step_tick_o,
    output logic             running_o,
    output logic [POS_W-1:0] position_o
);

    localparam int TW = $clog2(START_PERIOD + 1);
    localparam logic [TW-1:0] START_P = TW'(START_PERIOD);
    localparam logic [TW-1:0] STEP_P  = TW'(STEP_PERIOD);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [2:0]       phase_q, phase_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [TW-1:0]    period_q, period_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             last_dir_q, last_dir_d;
    logic             tick_q, tick_d;
    logic [3:0]       pattern;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            phase_q    <= 3'd0;
            timer_q    <= '0;
            period_q   <= START_P;
            pos_q      <= '0;
            last_dir_q <= 1'b1;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            timer_q    <= timer_d;
            period_q   <= period_d;
            pos_q      <= pos_d;
            last_dir_q <= last_dir_d;
            tick_q     <= tick_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        timer_d    = timer_q;
        period_d   = period_q;
        pos_d      = pos_q;
        last_dir_d = last_dir_q;
        tick_d     = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d  = '0;
                period_d = START_P;
                if (en_i) begin
                    state_d    = RUN;
                    last_dir_d = direction_i;
                end
            end
            RUN: begin
                if (!en_i) begin
                    // a falling enable wins over a coincident step: partial step is dropped
                    state_d  = IDLE;
                    timer_d  = '0;
                    period_d = START_P;
                end else if (timer_q == period_q - TW'(1)) begin
                    timer_d = '0;
                    tick_d  = 1'b1;
                    phase_d = direction_i ? phase_q + 3'd1 : phase_q - 3'd1;
                    pos_d   = direction_i ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
                    if (direction_i == last_dir_q) begin
                        if (int'(period_q) - RAMP_DEC >= STEP_PERIOD)
                            period_d = period_q - TW'(RAMP_DEC);
                        else
                            period_d = STEP_P;
                    end else begin
                        period_d   = START_P;
                        last_dir_d = direction_i;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (phase_q)
            3'd0:    pattern = 4'b1000;
            3'd1:    pattern = 4'b1100;
            3'd2:    pattern = 4'b0100;
            3'd3:    pattern = 4'b0110;
            3'd4:    pattern = 4'b0010;
            3'd5:    pattern = 4'b0011;
            3'd6:    pattern = 4'b0001;
            default: pattern = 4'b1001;
        endcase
    end

    assign coil_o      = (state_q == RUN || HOLD_EN != 0) ? pattern : 4'b0000;
    assign step_tick_o = tick_q;
    assign running_o   = (state_q == RUN);
    assign position_o  = pos_q;

endmodule

// File: tb/tb_cut_driver.sv
// Randomised and directed bench for cut_driver with a per-cycle scoreboard; a HOLD_EN=1 copy shares the stimulus.
module tb_cut_driver;

    localparam int SP = 10;
    localparam int CP = 4;
    localparam int RD = 2;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic          dir = 1'b1;
    logic [3:0]    coil, coil_h;
    logic          tick, tick_h, run, run_h;
    logic [PW-1:0] pos, pos_h;

    always #5 clk = ~clk;

    cut_driver #(.START_PERIOD(SP), .STEP_PERIOD(CP), .RAMP_DEC(RD), .HOLD_EN(0), .POS_W(PW)) dut (
        .clk(clk), .rst(rst), .en_i(en), .direction_i(dir),
        .coil_o(coil), .step_tick_o(tick), .running_o(run), .position_o(pos));

    cut_driver #(.START_PERIOD(SP), .STEP_PERIOD(CP), .RAMP_DEC(RD), .HOLD_EN(1), .POS_W(PW)) dut_h (
        .clk(clk), .rst(rst), .en_i(en), .direction_i(dir),
        .coil_o(coil_h), .step_tick_o(tick_h), .running_o(run_h), .position_o(pos_h));

    typedef struct packed {
        logic          tick;
        logic          run;
        logic [PW-1:0] pos;
        logic [3:0]    coil;
        logic [3:0]    coil_h;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_no = 0;

    logic [3:0] tbl [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                            4'b0010, 4'b0011, 4'b0001, 4'b1001};

    // Reference model: k counts steps since the ramp (re)started, period follows START - k*RAMP
    int m_run = 0, m_phase = 0, m_pos = 0, m_cnt = 0, m_k = 0, m_rdir = 1, m_tick = 0;

    function automatic int period_of(input int k);
        int p;
        p = SP - k * RD;
        return (p < CP) ? CP : p;
    endfunction

    task automatic model_edge(input logic r, input logic e, input logic d);
        m_tick = 0;
        if (r) begin
            m_run = 0; m_phase = 0; m_pos = 0; m_cnt = 0; m_k = 0; m_rdir = 1;
        end else if (m_run == 0) begin
            if (e) begin
                m_run = 1; m_cnt = 0; m_k = 0; m_rdir = int'(d);
            end
        end else if (!e) begin
            m_run = 0; m_cnt = 0; m_k = 0;
        end else begin
            m_cnt = m_cnt + 1;
            if (m_cnt == period_of(m_k)) begin
                m_tick  = 1;
                m_cnt   = 0;
                m_phase = (m_phase + (d ? 1 : 7)) % 8;
                m_pos   = (m_pos + (d ? 1 : (1 << PW) - 1)) % (1 << PW);
                if (int'(d) == m_rdir) begin
                    if (m_k < 1000) m_k = m_k + 1;
                end else begin
                    m_k = 0; m_rdir = int'(d);
                end
            end
        end
    endtask

    task automatic cyc(input logic r, input logic e, input logic d);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; dir = d;
        model_edge(r, e, d);
        x.tick   = (m_tick != 0);
        x.run    = (m_run != 0);
        x.pos    = PW'(m_pos);
        x.coil   = (m_run != 0) ? tbl[m_phase] : 4'b0000;
        x.coil_h = tbl[m_phase];
        q.push_back(x);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc_no);
        end
    endtask

    // Monitor: one expected tuple per edge, checked 1 time unit after the rising edge
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            cyc_no = cyc_no + 1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("step_tick", int'(tick), int'(x.tick));
                chk("running", int'(run), int'(x.run));
                chk("position", int'(pos), int'(x.pos));
                chk("coil", int'(coil), int'(x.coil));
                chk("coil_hold", int'(coil_h), int'(x.coil_h));
                chk("tick_hold", int'(tick_h), int'(x.tick));
                chk("pos_hold", int'(pos_h), int'(x.pos));
                chk("running_hold", int'(run_h), int'(x.run));
            end
        end
    end

    initial begin
        logic en_r, dir_r, rst_r;
        // reset, then forward run through ramp into cruise and a full phase wrap
        repeat (3) cyc(1'b1, 1'b0, 1'b1);
        repeat (70) cyc(1'b0, 1'b1, 1'b1);
        // reversal in the middle of a cruise interval
        for (int i = 0; i < 20; i++) begin
            if (m_cnt == 1) break;
            cyc(1'b0, 1'b1, 1'b1);
        end
        repeat (50) cyc(1'b0, 1'b1, 1'b0);
        // enable dropped exactly on the edge where a cruise step would fire
        for (int i = 0; i < 100; i++) begin
            if (m_run != 0 && m_cnt == CP - 1 && period_of(m_k) == CP) break;
            cyc(1'b0, 1'b1, 1'b0);
        end
        repeat (4) cyc(1'b0, 1'b0, 1'b0);
        repeat (30) cyc(1'b0, 1'b1, 1'b0);
        // reverse start straight from reset: position wraps below zero
        repeat (2) cyc(1'b1, 1'b0, 1'b1);
        repeat (25) cyc(1'b0, 1'b1, 1'b0);
        // reset in the middle of a run, held with enable high
        repeat (2) cyc(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 200; i++) begin
            if (m_pos == 5) break;
            cyc(1'b0, 1'b1, 1'b1);
        end
        repeat (15) cyc(1'b1, 1'b1, 1'b1);
        repeat (20) cyc(1'b0, 1'b1, 1'b1);
        // random enable/direction/reset traffic
        en_r = 1'b1; dir_r = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) en_r = ~en_r;
            if ($urandom_range(0, 24) == 0) dir_r = ~dir_r;
            rst_r = ($urandom_range(0, 799) == 0);
            cyc(rst_r, en_r, dir_r);
        end
        repeat (3) cyc(1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
